key_encoder: RTL and testbench



---
 rtl/key_pkg.sv | 22 ++
 rtl/key_debounce.sv | 44 ++++
 rtl/key_encoder.sv | 148 ++++++++++++++
 tb/tb_key_encoder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared constants and FSM state type for the key_encoder input stage.
package key_pkg;

  localparam logic [2:0] NOTE_NONE = 3'b000;
  localparam logic [2:0] NOTE_A    = 3'b001;
  localparam logic [2:0] NOTE_B    = 3'b010;
  localparam logic [2:0] NOTE_C    = 3'b011;
  localparam logic [2:0] NOTE_D    = 3'b100;
  localparam logic [2:0] NOTE_E    = 3'b101;
  localparam logic [2:0] NOTE_F    = 3'b110;
  localparam logic [2:0] NOTE_G    = 3'b111;

  localparam logic [2:0] OCT_MIN = 3'b001;
  localparam logic [2:0] OCT_MAX = 3'b011;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    SUSTAIN = 2'd2
  } key_state_e;

endpackage

// File: rtl/key_debounce.sv
// 2-FF synchronizer plus group debounce: any change in the group restarts one shared counter.
module key_debounce #(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_stable
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_stable;
  logic [CW-1:0]    r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_cand   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_cand;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/key_encoder.sv
// Debounced piano-key / octave encoder feeding the tone generator.
// Optional macro KEY_SUSTAIN_EN adds a SUSTAIN state holding isValid after release.
module key_encoder
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 7,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SUSTAIN_CYCLES  = 2500000
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic [NUM_KEYS-1:0] keysRaw,
  input  logic                octUpRaw,
  input  logic                octDownRaw,
  output logic [2:0]          note,
  output logic [2:0]          octave,
  output logic                isValid
);

  if (DEBOUNCE_CYCLES < 2 || SUSTAIN_CYCLES < 1) begin : g_param_check
    $error("key_encoder: DEBOUNCE_CYCLES must be >= 2 and SUSTAIN_CYCLES >= 1");
  end

  logic [NUM_KEYS-1:0] w_keys;
  logic [1:0]          w_oct;
  logic [2:0]          w_code;
  logic                w_any;
  logic                w_up_rise;
  logic                w_dn_rise;

  key_state_e r_state;
  logic [2:0] r_note;
  logic [2:0] r_octave;
  logic       r_valid;
  logic [1:0] r_oct_prev;

  key_debounce #(
    .WIDTH          (NUM_KEYS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_keys_db (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .i_raw   (keysRaw),
    .o_stable(w_keys)
  );

  key_debounce #(
    .WIDTH          (2),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_oct_db (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .i_raw   ({octDownRaw, octUpRaw}),
    .o_stable(w_oct)
  );

  // Scan high-to-low so the lowest set index is the last assignment and wins.
  always_comb begin
    w_code = NOTE_NONE;
    for (int unsigned i = NUM_KEYS; i > 0; i--) begin
      if (w_keys[i-1]) w_code = 3'(i);
    end
  end

  assign w_any     = |w_keys;
  assign w_up_rise = w_oct[0] & ~r_oct_prev[0];
  assign w_dn_rise = w_oct[1] & ~r_oct_prev[1];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_oct_prev <= '0;
      r_octave   <= OCT_MIN;
    end else begin
      r_oct_prev <= w_oct;
      if (w_up_rise && !w_dn_rise && r_octave != OCT_MAX) begin
        r_octave <= r_octave + 3'd1;
      end else if (w_dn_rise && !w_up_rise && r_octave != OCT_MIN) begin
        r_octave <= r_octave - 3'd1;
      end
    end
  end

`ifdef KEY_SUSTAIN_EN
  localparam int unsigned SW = $clog2(SUSTAIN_CYCLES + 1);
  localparam logic [SW-1:0] SUS_LAST = SW'(SUSTAIN_CYCLES - 1);
  logic [SW-1:0] r_sus_cnt;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= IDLE;
      r_note  <= NOTE_NONE;
      r_valid <= 1'b0;
`ifdef KEY_SUSTAIN_EN
      r_sus_cnt <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= PLAY;
            r_note  <= w_code;
            r_valid <= 1'b1;
          end
        end
        PLAY: begin
          if (w_any) begin
            r_note <= w_code;
          end else begin
`ifdef KEY_SUSTAIN_EN
            r_state   <= SUSTAIN;
            r_sus_cnt <= '0;
`else
            r_state <= IDLE;
            r_note  <= NOTE_NONE;
            r_valid <= 1'b0;
`endif
          end
        end
`ifdef KEY_SUSTAIN_EN
        SUSTAIN: begin
          if (w_any) begin
            r_state   <= PLAY;
            r_note    <= w_code;
            r_sus_cnt <= '0;
          end else if (r_sus_cnt == SUS_LAST) begin
            r_state <= IDLE;
            r_note  <= NOTE_NONE;
            r_valid <= 1'b0;
          end else begin
            r_sus_cnt <= r_sus_cnt + SW'(1);
          end
        end
`endif
        default: begin
          r_state <= IDLE;
          r_note  <= NOTE_NONE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign note    = r_note;
  assign octave  = r_octave;
  assign isValid = r_valid;

endmodule

// File: tb/tb_key_encoder.sv
// Directed self-checking bench for key_encoder (DEBOUNCE_CYCLES=4, SUSTAIN_CYCLES=10).
module tb_key_encoder;

  logic       clk;
  logic       rstN;
  logic [6:0] keysRaw;
  logic       octUpRaw;
  logic       octDownRaw;
  logic [2:0] note;
  logic [2:0] octave;
  logic       isValid;

  int n_tests = 0;
  int n_fail  = 0;

  key_encoder #(
    .NUM_KEYS       (7),
    .DEBOUNCE_CYCLES(4),
    .SUSTAIN_CYCLES (10)
  ) dut (
    .clk       (clk),
    .rstN      (rstN),
    .keysRaw   (keysRaw),
    .octUpRaw  (octUpRaw),
    .octDownRaw(octDownRaw),
    .note      (note),
    .octave    (octave),
    .isValid   (isValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rstN       = 1'b0;
    keysRaw    = '0;
    octUpRaw   = 1'b0;
    octDownRaw = 1'b0;
    edges(3);
    chk("rst_note",   8'(note),    8'h00);
    chk("rst_octave", 8'(octave),  8'h01);
    chk("rst_valid",  8'(isValid), 8'h00);
    @(negedge clk);
    rstN = 1'b1;
    edges(3);

    // Clean press of C: isValid first at the 8th edge
    @(negedge clk);
    keysRaw = 7'b0000100;
    edges(7);
    chk("c_valid_e7", 8'(isValid), 8'h00);
    edges(1);
    chk("c_valid_e8", 8'(isValid), 8'h01);
    chk("c_note",     8'(note),    8'h03);
    chk("c_octave",   8'(octave),  8'h01);

    // Release C
    @(negedge clk);
    keysRaw = '0;
    edges(7);
    chk("rel_valid_e7", 8'(isValid), 8'h01);
    edges(1);
`ifdef KEY_SUSTAIN_EN
    chk("sus_valid_e8", 8'(isValid), 8'h01);
    chk("sus_note_e8",  8'(note),    8'h03);
    edges(9);
    chk("sus_valid_e17", 8'(isValid), 8'h01);
    chk("sus_note_e17",  8'(note),    8'h03);
    edges(1);
    chk("sus_valid_e18", 8'(isValid), 8'h00);
    chk("sus_note_e18",  8'(note),    8'h00);
`else
    chk("rel_valid_e8", 8'(isValid), 8'h00);
    chk("rel_note_e8",  8'(note),    8'h00);
`endif

    // Bouncing A: toggle every 2 cycles, then hold
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      keysRaw = (i % 2 == 0) ? 7'b0000001 : 7'b0000000;
      edges(2);
      chk("bounce_valid", 8'(isValid), 8'h00);
    end
    @(negedge clk);
    keysRaw = 7'b0000001;
    edges(7);
    chk("bhold_valid_e7", 8'(isValid), 8'h00);
    edges(1);
    chk("bhold_valid_e8", 8'(isValid), 8'h01);
    chk("bhold_note",     8'(note),    8'h01);

    // A and G together: A wins; then drop A -> G without losing isValid
    @(negedge clk);
    keysRaw = 7'b1000001;
    edges(10);
    chk("ag_note",  8'(note),    8'h01);
    chk("ag_valid", 8'(isValid), 8'h01);
    @(negedge clk);
    keysRaw = 7'b1000000;
    for (int k = 1; k <= 8; k++) begin
      edges(1);
      chk("g_valid_hold", 8'(isValid), 8'h01);
      if (k == 7) chk("g_note_e7", 8'(note), 8'h01);
      if (k == 8) chk("g_note_e8", 8'(note), 8'h07);
    end

    // Octave up three times, saturating at 3
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      octUpRaw = 1'b1;
      edges(10);
      chk("oct_up", 8'(octave), (p == 0) ? 8'h02 : 8'h03);
      @(negedge clk);
      octUpRaw = 1'b0;
      edges(10);
    end
    @(negedge clk);
    octUpRaw   = 1'b1;
    octDownRaw = 1'b1;
    edges(10);
    chk("oct_both", 8'(octave), 8'h03);
    @(negedge clk);
    octUpRaw   = 1'b0;
    octDownRaw = 1'b0;
    edges(10);
    chk("oct_both_rel", 8'(octave), 8'h03);
    @(negedge clk);
    octDownRaw = 1'b1;
    edges(10);
    chk("oct_down", 8'(octave), 8'h02);
    @(negedge clk);
    octDownRaw = 1'b0;
    edges(10);
    chk("oct_note_held",  8'(note),    8'h07);
    chk("oct_valid_held", 8'(isValid), 8'h01);

    // Asynchronous reset mid-PLAY, G still held
    #2;
    rstN = 1'b0;
    #1;
    chk("arst_note",   8'(note),    8'h00);
    chk("arst_octave", 8'(octave),  8'h01);
    chk("arst_valid",  8'(isValid), 8'h00);
    @(negedge clk);
    rstN = 1'b1;
    edges(7);
    chk("post_rst_valid_e7", 8'(isValid), 8'h00);
    chk("post_rst_note_e7",  8'(note),    8'h00);
    edges(1);
    chk("post_rst_valid_e8", 8'(isValid), 8'h01);
    chk("post_rst_note_e8",  8'(note),    8'h07);
    chk("post_rst_octave",   8'(octave),  8'h01);

    // Release G
    @(negedge clk);
    keysRaw = '0;
`ifdef KEY_SUSTAIN_EN
    for (int k = 1; k <= 4; k++) begin
      edges(1);
      chk("rep_valid_pre", 8'(isValid), 8'h01);
    end
    @(negedge clk);
    keysRaw = 7'b0000010;
    for (int k = 1; k <= 8; k++) begin
      edges(1);
      chk("rep_valid", 8'(isValid), 8'h01);
      if (k == 4) chk("rep_note_sustain", 8'(note), 8'h07);
      if (k == 7) chk("rep_note_e7",      8'(note), 8'h07);
      if (k == 8) chk("rep_note_e8",      8'(note), 8'h02);
    end
`else
    edges(7);
    chk("g_rel_valid_e7", 8'(isValid), 8'h01);
    edges(1);
    chk("g_rel_valid_e8", 8'(isValid), 8'h00);
    chk("g_rel_note_e8",  8'(note),    8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
